// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with req/ack data-memory handshake and MEM/WB register.
// Optional MEM_TIMEOUT_EN aborts an access that waits TIMEOUT cycles without ack and sets mem_err.
module mem_stage #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_i,
   input  logic [4:0]        rw_i,
   input  logic [4:0]        desreg_i,
   input  logic              Regwrite_i,
   input  logic              MemToReg_i,
   input  logic              Memwrite_i,
   input  logic              lb_i,
   input  logic [31:0]       ALU_i,
   input  logic [31:0]       mem_din_i,
   input  logic [31:0]       wb_data_i,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              mem_stall,
   output logic [31:0]       wb_data_o,
   output logic [4:0]        rw_o,
   output logic [4:0]        desreg_o,
   output logic              Regwrite_o,
   output logic              halt_o,
   output logic              mem_err
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      r_state;
   logic        w_mem_op;
   logic        w_to;
   logic [7:0]  w_byte;
   logic [31:0] w_load;
   logic        w_unused;
   assign w_mem_op  = MemToReg_i | Memwrite_i;
   assign w_byte    = 8'(dmem_rdata >> {ALU_i[1:0], 3'b000});
   assign w_load    = lb_i ? {{24{w_byte[7]}}, w_byte} : dmem_rdata;
   assign mem_stall = (r_state == IDLE) ? w_mem_op : ~(dmem_ack | w_to);
   assign w_unused  = ^{ALU_i[31:ADDR_W+2], TIMEOUT};
`ifdef MEM_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT) : 8;
   logic [CW-1:0] r_cnt;
   assign w_to = (r_state == WAIT) && !dmem_ack && (r_cnt == CW'(TIMEOUT - 1));
`else
   assign w_to    = 1'b0;
   assign mem_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_data_o  <= '0;
         rw_o       <= '0;
         desreg_o   <= '0;
         Regwrite_o <= 1'b0;
         halt_o     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_cnt      <= '0;
         mem_err    <= 1'b0;
`endif
      end else if (r_state == IDLE) begin
         if (w_mem_op) begin
            r_state    <= WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= Memwrite_i;
            dmem_addr  <= ALU_i[ADDR_W+1:2];
            dmem_wdata <= mem_din_i;
            wb_data_o  <= '0;
            rw_o       <= '0;
            desreg_o   <= '0;
            Regwrite_o <= 1'b0;
            halt_o     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
`endif
         end else begin
            wb_data_o  <= wb_data_i;
            rw_o       <= rw_i;
            desreg_o   <= desreg_i;
            Regwrite_o <= Regwrite_i;
            halt_o     <= halt_i;
         end
      end else if (dmem_ack) begin
         // Inputs are still the frozen memory instruction, so they describe this result.
         r_state    <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         wb_data_o  <= dmem_we ? 32'd0 : w_load;
         rw_o       <= rw_i;
         desreg_o   <= desreg_i;
         Regwrite_o <= Regwrite_i & ~dmem_we;
         halt_o     <= halt_i;
`ifdef MEM_TIMEOUT_EN
      end else if (w_to) begin
         r_state    <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         mem_err    <= 1'b1;
      end else begin
         r_cnt      <= r_cnt + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven directed checks of mem_stage plus reset and wait-state sequences.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halt_i, Regwrite_i, MemToReg_i, Memwrite_i, lb_i, dmem_ack;
   logic [4:0]  rw_i, desreg_i;
   logic [31:0] ALU_i, mem_din_i, wb_data_i, dmem_rdata;
   logic        dmem_req, dmem_we, mem_stall, Regwrite_o, halt_o, mem_err;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata, wb_data_o;
   logic [4:0]  rw_o, desreg_o;
   int checks = 0;
   int errors = 0;

   mem_stage #(.ADDR_W(10), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .halt_i(halt_i), .rw_i(rw_i), .desreg_i(desreg_i),
      .Regwrite_i(Regwrite_i), .MemToReg_i(MemToReg_i), .Memwrite_i(Memwrite_i),
      .lb_i(lb_i), .ALU_i(ALU_i), .mem_din_i(mem_din_i), .wb_data_i(wb_data_i),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .wb_data_o(wb_data_o), .rw_o(rw_o),
      .desreg_o(desreg_o), .Regwrite_o(Regwrite_o), .halt_o(halt_o), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mtr, mw, lb;
      logic [31:0] alu, din, wbd, rdata;
      logic [4:0]  rw, ds;
      logic        rwen, halt;
      int          dly;
      logic [31:0] e_wb;
      logic        e_rwen;
      logic [9:0]  e_addr;
   } vec_t;

   vec_t v[10];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic nop();
      halt_i = 0; Regwrite_i = 0; MemToReg_i = 0; Memwrite_i = 0; lb_i = 0;
      rw_i = 0; desreg_i = 0; ALU_i = 0; mem_din_i = 0; wb_data_i = 0;
      dmem_ack = 0; dmem_rdata = 0;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t t, input int i);
      logic st;
      st = t.mw;
      MemToReg_i = t.mtr; Memwrite_i = t.mw; lb_i = t.lb; ALU_i = t.alu;
      mem_din_i = t.din; wb_data_i = t.wbd; rw_i = t.rw; desreg_i = t.ds;
      Regwrite_i = t.rwen; halt_i = t.halt; dmem_ack = 0; dmem_rdata = 32'hXXXX_XXXX;
      @(negedge clk);
      chk($sformatf("v%0d stall_issue", i), 32'(mem_stall), 32'(t.mtr | t.mw));
      edge1();
      if (t.mtr | t.mw) begin
         chk($sformatf("v%0d req", i), 32'(dmem_req), 1);
         chk($sformatf("v%0d we", i), 32'(dmem_we), 32'(st));
         chk($sformatf("v%0d bubble", i), {wb_data_o[30:0], Regwrite_o}, 0);
         for (int c = 0; c < t.dly; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d stall_wait%0d", i, c), 32'(mem_stall), 1);
            chk($sformatf("v%0d addr_wait%0d", i, c), 32'(dmem_addr), 32'(t.e_addr));
            if (st) chk($sformatf("v%0d wdata_wait%0d", i, c), dmem_wdata, t.din);
            edge1();
         end
         dmem_ack = 1; dmem_rdata = t.rdata;
         @(negedge clk);
         chk($sformatf("v%0d stall_ack", i), 32'(mem_stall), 0);
         chk($sformatf("v%0d addr", i), 32'(dmem_addr), 32'(t.e_addr));
         if (st) chk($sformatf("v%0d wdata", i), dmem_wdata, t.din);
         edge1();
         dmem_ack = 0;
         chk($sformatf("v%0d req_drop", i), {dmem_req, dmem_we}, 0);
      end
      chk($sformatf("v%0d wb_data", i), wb_data_o, t.e_wb);
      chk($sformatf("v%0d regwrite", i), 32'(Regwrite_o), 32'(t.e_rwen));
      if (!st) chk($sformatf("v%0d rw/ds/halt", i), {rw_o, desreg_o, halt_o}, {t.rw, t.ds, t.halt});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        mtr mw lb alu           din           wbd           rdata         rw  ds rwen halt dly e_wb          e_rwen e_addr
      v[0] = '{0, 0, 0, 32'h0,        32'h0,        32'h12345678, 32'h0,        5,  7, 1, 0, 0, 32'h12345678, 1, 10'h0};
      v[1] = '{1, 0, 0, 32'h10,       32'h0,        32'h0,        32'hCAFEBABE, 3,  3, 1, 0, 0, 32'hCAFEBABE, 1, 10'd4};
      v[2] = '{1, 0, 1, 32'h13,       32'h0,        32'h0,        32'h80FF7F01, 4,  4, 1, 0, 0, 32'hFFFFFF80, 1, 10'd4};
      v[3] = '{1, 0, 1, 32'h11,       32'h0,        32'h0,        32'h80FF7F01, 6,  6, 1, 0, 1, 32'h0000007F, 1, 10'd4};
      v[4] = '{1, 0, 1, 32'h10,       32'h0,        32'h0,        32'h80FF7F01, 8,  9, 1, 0, 0, 32'h00000001, 1, 10'd4};
      v[5] = '{1, 0, 1, 32'h12,       32'h0,        32'h0,        32'h80FF7F01, 8,  9, 1, 0, 0, 32'hFFFFFFFF, 1, 10'd4};
      v[6] = '{0, 1, 0, 32'h20,       32'hDEADBEEF, 32'h0,        32'h0,        9,  9, 1, 0, 3, 32'h0,        0, 10'd8};
      v[7] = '{1, 1, 0, 32'h24,       32'h55AA55AA, 32'h0,        32'h0,        10, 10, 1, 0, 0, 32'h0,        0, 10'd9};
      v[8] = '{1, 0, 0, 32'h80000FFE, 32'h0,        32'h0,        32'h11223344, 11, 12, 1, 0, 2, 32'h11223344, 1, 10'h3FF};
      v[9] = '{0, 0, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 32'h0,        31, 30, 0, 1, 0, 32'hA5A5A5A5, 0, 10'h0};
      nop();
      #3;
      chk("reset_out", {dmem_req, dmem_we, Regwrite_o, halt_o, mem_err}, 0);
      chk("reset_data", wb_data_o | dmem_wdata | 32'(dmem_addr), 0);
      @(negedge clk);
      rst = 1;
      edge1();
      for (int i = 0; i < 10; i++) apply(v[i], i);
      nop();
      // reset in the middle of a pending store
      apply(v[0], 10);
      Memwrite_i = 1; ALU_i = 32'h44; mem_din_i = 32'h0BADF00D;
      edge1();
      chk("rst_pre_req", {dmem_req, dmem_we}, 2'b11);
      #2 rst = 0;
      #1;
      chk("rst_async", {dmem_req, dmem_we, Regwrite_o}, 0);
      chk("rst_async_addr", 32'(dmem_addr) | dmem_wdata, 0);
      nop();
      @(negedge clk);
      rst = 1;
      edge1();
      apply(v[0], 11);
      nop();
      // ack withheld for a long time
      MemToReg_i = 1; Regwrite_i = 1; rw_i = 2; ALU_i = 32'h8;
      edge1();
`ifdef MEM_TIMEOUT_EN
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("to_stall%0d", c), 32'(mem_stall), 1);
         edge1();
      end
      @(negedge clk);
      chk("to_stall_abort", 32'(mem_stall), 0);
      edge1();
      nop();
      chk("to_err", {mem_err, dmem_req, Regwrite_o}, 3'b100);
      repeat (5) edge1();
      chk("to_err_sticky", 32'(mem_err), 1);
`else
      repeat (70) begin
         @(negedge clk);
         chk("nto_stall", {mem_stall, dmem_req, mem_err}, 3'b110);
         edge1();
      end
      dmem_ack = 1; dmem_rdata = 32'h0F0F0F0F;
      edge1();
      nop();
      chk("nto_result", wb_data_o, 32'h0F0F0F0F);
      chk("nto_regwrite", {Regwrite_o, 27'd0, rw_o}, {1'b1, 27'd0, 5'd2});
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
